// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: turns M-stage exceptions, mret and
// synchronized interrupts into a one-cycle CSR trap-write strobe followed by
// a one-cycle fetch redirect, killing the offending instruction at take.
module trap_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_sm,
  input  logic [31:0] pc_sm,
  input  logic [31:0] instr_sm,
  input  logic        instr_misalign_sm,
  input  logic        illegal_sm,
  input  logic        ebreak_sm,
  input  logic        ecall_sm,
  input  logic        load_misalign_sm,
  input  logic        store_misalign_sm,
  input  logic        mret_sm,
  input  logic [31:0] bad_addr_sm,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        CSR_ENABLE_SM,
  input  logic [11:0] CSR_WADR_SM,
  input  logic [31:0] CSR_WDATA_SM,
  input  logic [31:0] MSTATUS_RC,
  input  logic [31:0] MTVEC_VALUE_RC,
  input  logic [31:0] MIE_VALUE_RC,
  input  logic [31:0] MEPC_SC,
  input  logic [31:0] MCAUSE_SC,
  output logic        EXCEPTION_SM,
  output logic [31:0] MSTATUS_WDATA_SM,
  output logic [31:0] MIP_WDATA_SM,
  output logic [31:0] MEPC_WDATA_SM,
  output logic [31:0] MCAUSE_WDATA_SM,
  output logic [31:0] MTVAL_WDATA_SM,
  output logic        kill_sm,
  output logic        flush_sm,
  output logic        stall_sm,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

  // Decoded trap request for the current M-stage instruction.
  typedef struct packed {
    logic        intr;
    logic        mret;
    logic [31:0] cause;
    logic [31:0] tval;
  } trap_t;

  localparam logic [11:0] MTVAL_ADR = 12'h343;

  state_t      state, state_nx;
  trap_t       dec;
  logic [SYNC_STAGES-1:0] meip_q, mtip_q;
  logic        meip_s, mtip_s;
  logic        irq_e, irq_t, irq_ok, exc_any, take;
  logic [31:0] mtval_shadow;
  logic [31:0] mstatus_trap, mstatus_mret;
  logic [31:0] vec_base, rpc_nx;
  logic        exc_o, flush_o, redir_o;
  logic        unused_ok;

  assign unused_ok = ^{MIE_VALUE_RC[31:12], MIE_VALUE_RC[10:8], MIE_VALUE_RC[6:0],
                       dec.cause[31:30]};

  // Interrupt line synchronizers; the last stage is the usable level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meip_q <= '0;
      mtip_q <= '0;
    end else begin
      meip_q <= {meip_q[SYNC_STAGES-2:0], ext_irq};
      mtip_q <= {mtip_q[SYNC_STAGES-2:0], timer_irq};
    end
  end

  assign meip_s = meip_q[SYNC_STAGES-1];
  assign mtip_s = mtip_q[SYNC_STAGES-1];

  assign irq_e   = MSTATUS_RC[3] & meip_s & MIE_VALUE_RC[11];
  assign irq_t   = MSTATUS_RC[3] & mtip_s & MIE_VALUE_RC[7];
  assign irq_ok  = irq_e | irq_t;
  assign exc_any = instr_misalign_sm | illegal_sm | ebreak_sm | ecall_sm |
                   load_misalign_sm | store_misalign_sm;

  // Take only from IDLE; reset forces kill low even if state is stale.
  assign take    = reset_n & (state == IDLE) & valid_sm & (irq_ok | exc_any | mret_sm);
  assign kill_sm = take;

  // Priority decode of cause and trap value; interrupts beat exceptions.
  always_comb begin
    dec = '0;
    if (irq_e) begin
      dec.intr  = 1'b1;
      dec.cause = 32'h8000_000B;
    end else if (irq_t) begin
      dec.intr  = 1'b1;
      dec.cause = 32'h8000_0007;
    end else if (instr_misalign_sm) begin
      dec.cause = 32'd0;
      dec.tval  = bad_addr_sm;
    end else if (illegal_sm) begin
      dec.cause = 32'd2;
      dec.tval  = instr_sm;
    end else if (ebreak_sm) begin
      dec.cause = 32'd3;
      dec.tval  = pc_sm;
    end else if (ecall_sm) begin
      dec.cause = 32'd11;
    end else if (load_misalign_sm) begin
      dec.cause = 32'd4;
      dec.tval  = bad_addr_sm;
    end else if (store_misalign_sm) begin
      dec.cause = 32'd6;
      dec.tval  = bad_addr_sm;
    end else if (mret_sm) begin
      dec.mret  = 1'b1;
    end
  end

  // mstatus images for trap entry (stack MIE into MPIE) and mret (unstack).
  always_comb begin
    mstatus_trap        = MSTATUS_RC;
    mstatus_trap[7]     = MSTATUS_RC[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_mret        = MSTATUS_RC;
    mstatus_mret[3]     = MSTATUS_RC[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;
  end

  // Redirect target: mepc for mret, vectored slot for interrupts in mode 1.
  always_comb begin
    vec_base = {MTVEC_VALUE_RC[31:2], 2'b00};
    if (dec.mret)
      rpc_nx = MEPC_SC;
    else if (dec.intr && (MTVEC_VALUE_RC[1:0] == 2'b01))
      rpc_nx = vec_base + {dec.cause[29:0], 2'b00};
    else
      rpc_nx = vec_base;
  end

  // CSR write data and redirect target captured at take, held until next take.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      MSTATUS_WDATA_SM <= '0;
      MIP_WDATA_SM     <= '0;
      MEPC_WDATA_SM    <= '0;
      MCAUSE_WDATA_SM  <= '0;
      MTVAL_WDATA_SM   <= '0;
      redirect_pc      <= '0;
    end else if (take) begin
      MIP_WDATA_SM <= {20'b0, meip_s, 3'b0, mtip_s, 7'b0};
      redirect_pc  <= rpc_nx;
      if (dec.mret) begin
        MSTATUS_WDATA_SM <= mstatus_mret;
        MEPC_WDATA_SM    <= MEPC_SC;
        MCAUSE_WDATA_SM  <= MCAUSE_SC;
        MTVAL_WDATA_SM   <= mtval_shadow;
      end else begin
        MSTATUS_WDATA_SM <= mstatus_trap;
        MEPC_WDATA_SM    <= pc_sm;
        MCAUSE_WDATA_SM  <= dec.cause;
        MTVAL_WDATA_SM   <= dec.tval;
      end
    end
  end

  // Local copy of mtval so mret can rewrite it; trap writes beat CSR snoop.
  always_ff @(posedge clk) begin
    if (!reset_n)
      mtval_shadow <= '0;
    else if (EXCEPTION_SM)
      mtval_shadow <= MTVAL_WDATA_SM;
    else if (CSR_ENABLE_SM && (CSR_WADR_SM == MTVAL_ADR) && !kill_sm)
      mtval_shadow <= CSR_WDATA_SM;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // FSM next state and per-state strobes.
  always_comb begin
    state_nx = state;
    exc_o    = 1'b0;
    flush_o  = 1'b0;
    redir_o  = 1'b0;
    case (state)
      IDLE:     if (take) state_nx = COMMIT;
      COMMIT: begin
        exc_o    = 1'b1;
        flush_o  = 1'b1;
        state_nx = REDIRECT;
      end
      REDIRECT: begin
        redir_o  = 1'b1;
        flush_o  = 1'b1;
        state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  // Strobes are masked while reset is asserted, before state has cleared.
  assign EXCEPTION_SM   = exc_o & reset_n;
  assign flush_sm       = flush_o & reset_n;
  assign stall_sm       = flush_o & reset_n;
  assign redirect_valid = redir_o & reset_n;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: each taken instruction pushes its expected
// CSR write set; the monitor pops it on EXCEPTION_SM and checks the redirect.
module tb_trap_ctrl;

  typedef struct {
    logic [31:0] mepc, mcause, mtval, mstatus, mip, rpc;
    bit          take;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_sm = 1'b0;
  logic [31:0] pc_sm = '0, instr_sm = '0, bad_addr_sm = '0;
  logic        instr_misalign_sm = 1'b0, illegal_sm = 1'b0, ebreak_sm = 1'b0;
  logic        ecall_sm = 1'b0, load_misalign_sm = 1'b0, store_misalign_sm = 1'b0;
  logic        mret_sm = 1'b0;
  logic        ext_irq = 1'b0, timer_irq = 1'b0;
  logic        CSR_ENABLE_SM = 1'b0;
  logic [11:0] CSR_WADR_SM = '0;
  logic [31:0] CSR_WDATA_SM = '0;
  logic [31:0] MSTATUS_RC = '0, MTVEC_VALUE_RC = '0, MIE_VALUE_RC = '0;
  logic [31:0] MEPC_SC = '0, MCAUSE_SC = '0;
  logic        EXCEPTION_SM, kill_sm, flush_sm, stall_sm, redirect_valid;
  logic [31:0] MSTATUS_WDATA_SM, MIP_WDATA_SM, MEPC_WDATA_SM, MCAUSE_WDATA_SM;
  logic [31:0] MTVAL_WDATA_SM, redirect_pc;

  trap_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .valid_sm(valid_sm), .pc_sm(pc_sm),
    .instr_sm(instr_sm), .instr_misalign_sm(instr_misalign_sm),
    .illegal_sm(illegal_sm), .ebreak_sm(ebreak_sm), .ecall_sm(ecall_sm),
    .load_misalign_sm(load_misalign_sm), .store_misalign_sm(store_misalign_sm),
    .mret_sm(mret_sm), .bad_addr_sm(bad_addr_sm), .ext_irq(ext_irq),
    .timer_irq(timer_irq), .CSR_ENABLE_SM(CSR_ENABLE_SM),
    .CSR_WADR_SM(CSR_WADR_SM), .CSR_WDATA_SM(CSR_WDATA_SM),
    .MSTATUS_RC(MSTATUS_RC), .MTVEC_VALUE_RC(MTVEC_VALUE_RC),
    .MIE_VALUE_RC(MIE_VALUE_RC), .MEPC_SC(MEPC_SC), .MCAUSE_SC(MCAUSE_SC),
    .EXCEPTION_SM(EXCEPTION_SM), .MSTATUS_WDATA_SM(MSTATUS_WDATA_SM),
    .MIP_WDATA_SM(MIP_WDATA_SM), .MEPC_WDATA_SM(MEPC_WDATA_SM),
    .MCAUSE_WDATA_SM(MCAUSE_WDATA_SM), .MTVAL_WDATA_SM(MTVAL_WDATA_SM),
    .kill_sm(kill_sm), .flush_sm(flush_sm), .stall_sm(stall_sm),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_fail = 0;
  exp_t sb_q[$];
  exp_t cur;
  bit   redir_pend = 0;
  logic [31:0] shadow = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour; flags = {mret, store, load, ecall, ebreak, illegal, imis}.
  function automatic exp_t model(input logic [31:0] mst, mtvec, mie, mepc_sc, mcause_sc,
                                 input logic meip, mtip,
                                 input logic [31:0] pc, instr, bad, input logic [6:0] fl,
                                 input logic [31:0] shd);
    exp_t e;
    logic intr;
    e = '{default: '0};
    intr = 1'b0;
    e.take = 1'b1;
    e.mip  = (meip ? 32'h800 : 32'h0) | (mtip ? 32'h80 : 32'h0);
    e.mepc = pc;
    if (mst[3] && meip && mie[11])      begin intr = 1; e.mcause = 32'h8000000B; end
    else if (mst[3] && mtip && mie[7])  begin intr = 1; e.mcause = 32'h80000007; end
    else if (fl[0]) begin e.mcause = 0;  e.mtval = bad;   end
    else if (fl[1]) begin e.mcause = 2;  e.mtval = instr; end
    else if (fl[2]) begin e.mcause = 3;  e.mtval = pc;    end
    else if (fl[3]) begin e.mcause = 11; e.mtval = 0;     end
    else if (fl[4]) begin e.mcause = 4;  e.mtval = bad;   end
    else if (fl[5]) begin e.mcause = 6;  e.mtval = bad;   end
    else if (fl[6]) begin
      e.mstatus = (mst & ~32'h1888) | 32'h1880 | (mst[7] ? 32'h8 : 32'h0);
      e.mepc = mepc_sc; e.mcause = mcause_sc; e.mtval = shd; e.rpc = mepc_sc;
      return e;
    end else begin
      e.take = 1'b0;
      return e;
    end
    e.mstatus = (mst & ~32'h1888) | 32'h1800 | (mst[3] ? 32'h80 : 32'h0);
    e.rpc = {mtvec[31:2], 2'b00};
    if (intr && mtvec[1:0] == 2'b01) e.rpc = e.rpc + 4 * e.mcause[30:0];
    return e;
  endfunction

  // Monitor: pop on the trap strobe, check redirect one cycle later.
  always @(negedge clk) begin
    if (redir_pend) begin
      chk("redir_vld", {31'b0, redirect_valid}, 32'd1);
      chk("redir_pc", redirect_pc, cur.rpc);
      chk("redir_flush", {30'b0, flush_sm, stall_sm}, 32'd3);
      redir_pend = 0;
    end else if (redirect_valid) begin
      chk("redir_spurious", {31'b0, redirect_valid}, 32'd0);
    end
    if (EXCEPTION_SM) begin
      if (sb_q.size() == 0) begin
        chk("exc_spurious", {31'b0, EXCEPTION_SM}, 32'd0);
      end else begin
        cur = sb_q.pop_front();
        chk("mepc", MEPC_WDATA_SM, cur.mepc);
        chk("mcause", MCAUSE_WDATA_SM, cur.mcause);
        chk("mtval", MTVAL_WDATA_SM, cur.mtval);
        chk("mstatus", MSTATUS_WDATA_SM, cur.mstatus);
        chk("mip", MIP_WDATA_SM, cur.mip);
        chk("commit_flush", {30'b0, flush_sm, stall_sm}, 32'd3);
        redir_pend = 1;
      end
    end
  end

  task automatic set_flags(input logic [6:0] fl);
    {mret_sm, store_misalign_sm, load_misalign_sm, ecall_sm, ebreak_sm,
     illegal_sm, instr_misalign_sm} = fl;
  endtask

  // Drive one M-stage instruction; hold=1 keeps an illegal in the COMMIT cycle.
  task automatic issue(input logic [31:0] pc, instr, bad, input logic [6:0] fl,
                       input exp_t e, input bit hold);
    @(posedge clk); #1;
    valid_sm = 1; pc_sm = pc; instr_sm = instr; bad_addr_sm = bad; set_flags(fl);
    @(negedge clk);
    chk("kill", {31'b0, kill_sm}, {31'b0, e.take});
    if (e.take) begin
      sb_q.push_back(e);
      shadow = e.mtval;
    end
    @(posedge clk); #1;
    if (hold) begin
      set_flags(7'b0000010); instr_sm = 32'h0BAD0BAD;
      @(negedge clk);
      chk("kill_in_commit", {31'b0, kill_sm}, 32'd0);
      @(posedge clk); #1;
    end
    valid_sm = 0; set_flags(7'b0);
    repeat (hold ? 2 : 3) @(posedge clk);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [6:0]  fl;
    logic [31:0] pc, ms, tv;

    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    chk("rst_strobes", {28'b0, EXCEPTION_SM, flush_sm, stall_sm, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_mepc", MEPC_WDATA_SM, 32'd0);
    chk("rst_mstatus", MSTATUS_WDATA_SM, 32'd0);

    // Illegal instruction, direct mode.
    MTVEC_VALUE_RC = 32'h80; MSTATUS_RC = 32'h8;
    e = '{mepc:32'h100, mcause:32'd2, mtval:32'hFFFFFFFF, mstatus:32'h1880,
          mip:32'h0, rpc:32'h80, take:1'b1};
    issue(32'h100, 32'hFFFFFFFF, 32'h0, 7'b0000010, e, 0);

    // Timer interrupt, vectored mode.
    timer_irq = 1; MIE_VALUE_RC = 32'h80; MTVEC_VALUE_RC = 32'h201; settle();
    e = '{mepc:32'h40, mcause:32'h80000007, mtval:32'h0, mstatus:32'h1880,
          mip:32'h80, rpc:32'h21C, take:1'b1};
    issue(32'h40, 32'h13, 32'h0, 7'b0, e, 0);
    timer_irq = 0; MIE_VALUE_RC = 0; settle();

    // CSR write to mtval feeds the shadow, then mret restores it.
    @(posedge clk); #1;
    CSR_ENABLE_SM = 1; CSR_WADR_SM = 12'h343; CSR_WDATA_SM = 32'h55;
    @(posedge clk); #1;
    CSR_ENABLE_SM = 0; shadow = 32'h55;
    MSTATUS_RC = 32'h1880; MEPC_SC = 32'h104; MCAUSE_SC = 32'hB;
    e = '{mepc:32'h104, mcause:32'hB, mtval:32'h55, mstatus:32'h1888,
          mip:32'h0, rpc:32'h104, take:1'b1};
    issue(32'h200, 32'h30200073, 32'h0, 7'b1000000, e, 0);

    // ecall beats load misalign; an illegal during COMMIT is not taken.
    MSTATUS_RC = 32'h0; MTVEC_VALUE_RC = 32'h401;
    e = '{mepc:32'h300, mcause:32'd11, mtval:32'h0, mstatus:32'h1800,
          mip:32'h0, rpc:32'h400, take:1'b1};
    issue(32'h300, 32'h73, 32'h1234, 7'b0011000, e, 1);

    // External interrupt wins over an illegal on the same instruction.
    ext_irq = 1; MIE_VALUE_RC = 32'h800; MSTATUS_RC = 32'h8; MTVEC_VALUE_RC = 32'h301;
    settle();
    e = '{mepc:32'h200, mcause:32'h8000000B, mtval:32'h0, mstatus:32'h1880,
          mip:32'h800, rpc:32'h32C, take:1'b1};
    issue(32'h200, 32'hDEAD, 32'h0, 7'b0000010, e, 0);

    // Interrupts globally disabled: plain instruction is not taken.
    MSTATUS_RC = 32'h0;
    e = '{default: '0};
    issue(32'h204, 32'h13, 32'h0, 7'b0, e, 0);
    ext_irq = 0; MIE_VALUE_RC = 0; settle();

    // Reset while in COMMIT: trap is abandoned, everything clears.
    @(posedge clk); #1;
    valid_sm = 1; pc_sm = 32'h500; illegal_sm = 1; MSTATUS_RC = 32'h8;
    @(posedge clk); #1;
    reset_n = 0;
    @(negedge clk);
    chk("rst_in_commit_exc", {31'b0, EXCEPTION_SM}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_kill", {31'b0, kill_sm}, 32'd0);
    chk("rst2_strobes", {28'b0, EXCEPTION_SM, flush_sm, stall_sm, redirect_valid}, 32'd0);
    chk("rst2_rpc", redirect_pc, 32'd0);
    chk("rst2_mtval", MTVAL_WDATA_SM, 32'd0);
    chk("rst2_mcause", MCAUSE_WDATA_SM, 32'd0);
    @(posedge clk); #1;
    valid_sm = 0; illegal_sm = 0; reset_n = 1; shadow = 0;
    @(negedge clk);
    chk("post_rst_idle", {29'b0, kill_sm, flush_sm, redirect_valid}, 32'd0);

    // Random exception/mret mix with interrupts idle.
    for (int i = 0; i < 12; i++) begin
      fl = 7'($urandom_range(0, 127));
      pc = $urandom & 32'hFFFFFFFC; ms = $urandom; tv = $urandom;
      MSTATUS_RC = ms; MTVEC_VALUE_RC = tv; MEPC_SC = $urandom; MCAUSE_SC = $urandom;
      bad_addr_sm = $urandom;
      e = model(ms, tv, MIE_VALUE_RC, MEPC_SC, MCAUSE_SC, 1'b0, 1'b0,
                pc, 32'hC0DE0000 | 32'(i), bad_addr_sm, fl, shadow);
      issue(pc, 32'hC0DE0000 | 32'(i), bad_addr_sm, fl, e, 0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
